// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: shared burst length, command encodings and responder states
package burst_ram_pkg;
  localparam int BURST_LENGTH = 4;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  localparam int BEAT_BITWIDTH = 2;
  typedef logic [BEAT_BITWIDTH-1:0] beat_t;
  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ_WAIT, READ_DATA} state_t;
endpackage

// File: rtl/burst_ram_responder_if.sv
// burst_ram_responder_if: burst RAM command bus between an initiator (master) and the responder (slave)
interface burst_ram_responder_if #(
  parameter int DEPTH_BITWIDTH = 21
);
  logic                      cmd;
  logic                      cmd_en;
  logic [DEPTH_BITWIDTH-1:0] addr;
  logic [63:0]               wr_data;
  logic [7:0]                data_mask;
  logic [63:0]               rd_data;
  logic                      rd_data_valid;
  logic                      init_calib;
  logic                      busy;
  logic                      cmd_error;
  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, init_calib, busy, cmd_error
  );
  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, init_calib, busy, cmd_error
  );
endinterface

// File: rtl/burst_ram_storage.sv
// burst_ram_storage: simple dual-port 64-bit RAM, byte write enables, registered read port
module burst_ram_storage #(
  parameter int ADDR_BITWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [7:0]               i_be,
  input  logic [ADDR_BITWIDTH-1:0] i_waddr,
  input  logic [63:0]              i_wdata,
  input  logic                     i_re,
  input  logic [ADDR_BITWIDTH-1:0] i_raddr,
  output logic [63:0]              o_rdata
);
  logic [63:0] r_mem [2**ADDR_BITWIDTH];
  logic [63:0] r_rdata;
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++)
      if (i_we && i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
  end
  // Output register holds the last beat until the next read enable.
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/burst_ram_responder.sv
// burst_ram_responder: block-RAM stand-in for the PSRAM controller, 4-beat bursts with PSRAM-like timing.
// Define BURST_RAM_DATA_MASK_EN to honour data_mask; otherwise every byte of every beat is written.
module burst_ram_responder
  import burst_ram_pkg::*;
#(
  parameter int DEPTH_BITWIDTH   = 21,
  parameter int STORAGE_BITWIDTH = 12,
  parameter int READ_LATENCY     = 8,
  parameter int COMMAND_INTERVAL = 14,
  parameter int INIT_CYCLES      = 16
) (
  input logic clk,
  input logic rst,
  burst_ram_responder_if.slave bus
);
  localparam int SW = STORAGE_BITWIDTH;
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int CW = $clog2(COMMAND_INTERVAL + 1);
  state_t r_state, w_state_nx;
  logic [IW-1:0] r_init_cnt;
  logic [CW-1:0] r_interval;
  logic [4:0] r_wait;
  beat_t r_beat;
  logic [SW-1:0] r_addr, w_waddr, w_raddr;
  logic r_valid, r_err, w_busy, w_accept, w_write, w_we, w_re, w_unused;
  logic [7:0] w_be;
  assign w_busy = r_state != IDLE || r_interval != '0;
  assign w_accept = bus.cmd_en && !w_busy;
  assign w_write = bus.cmd == CMD_WRITE;
  assign w_we = !rst && ((w_accept && w_write) || r_state == WRITE);
  assign w_re = r_state == READ_DATA;
  assign w_waddr = w_accept ? bus.addr[SW-1:0] : r_addr + SW'(r_beat);
  assign w_raddr = r_addr + SW'(r_beat);
`ifdef BURST_RAM_DATA_MASK_EN
  assign w_be = ~bus.data_mask;
`else
  assign w_be = 8'hFF;
`endif
  assign w_unused = ^{bus.addr[DEPTH_BITWIDTH-1:SW], bus.data_mask};
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      INIT:             if (r_init_cnt == IW'(INIT_CYCLES - 1)) w_state_nx = IDLE;
      IDLE:             if (w_accept) w_state_nx = w_write ? WRITE : (READ_LATENCY > 2 ? READ_WAIT : READ_DATA);
      WRITE, READ_DATA: if (r_beat == beat_t'(BURST_LENGTH - 1)) w_state_nx = IDLE;
      READ_WAIT:        if (r_wait == '0) w_state_nx = READ_DATA;
      default:          w_state_nx = INIT;
    endcase
  end
  // Write beat 0 lands on the accept cycle, so the write beat counter starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_interval <= '0;
      r_wait     <= '0;
      r_beat     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_init_cnt <= r_init_cnt + IW'(r_state == INIT);
      r_interval <= w_accept ? CW'(COMMAND_INTERVAL - 1) : r_interval - CW'(r_interval != '0);
      r_wait     <= w_accept ? 5'(READ_LATENCY > 2 ? READ_LATENCY - 3 : 0) : r_wait - 5'(r_state == READ_WAIT);
      r_beat     <= w_accept ? beat_t'(w_write) : r_beat + beat_t'(r_state == WRITE || r_state == READ_DATA);
      r_valid    <= w_re;
      r_err      <= r_err || (bus.cmd_en && w_busy);
    end
  end
  always_ff @(posedge clk) begin
    if (w_accept) r_addr <= bus.addr[SW-1:0];
  end
  burst_ram_storage #(.ADDR_BITWIDTH(SW)) u_storage (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_waddr (w_waddr),
    .i_wdata (bus.wr_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (bus.rd_data)
  );
  assign bus.rd_data_valid = r_valid;
  assign bus.init_calib = r_state != INIT;
  assign bus.busy = w_busy;
  assign bus.cmd_error = r_err;
endmodule

// File: tb/tb_burst_ram_responder.sv
// tb_burst_ram_responder: directed bursts; read beats checked by a scoreboard monitor for data and cycle
module tb_burst_ram_responder;
  localparam int LAT = 8;
  localparam logic [63:0] A0 = 64'hA0A0_0000_0000_0FFF, A1 = 64'hA1A1_0000_0000_0000;
  localparam logic [63:0] A2 = 64'hA2A2_0000_0000_0001, A3 = 64'hA3A3_0000_0000_0002;
  localparam logic [63:0] B0 = 64'hB0B0_1234_5678_0003;
  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111, D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333, D4 = 64'h4444_4444_4444_4444;
`ifdef BURST_RAM_DATA_MASK_EN
  localparam logic [63:0] MV = 64'h0000_0000_FFFF_FFFF;
`else
  localparam logic [63:0] MV = 64'h0;
`endif
  typedef struct {logic [63:0] data; int cyc;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, failures = 0;
  exp_t sb[$];
  burst_ram_responder_if #(.DEPTH_BITWIDTH(21)) bus ();
  burst_ram_responder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [20:0] a, input logic [63:0] d0, d1, d2, d3, input logic [7:0] m);
    chk("wr_accept_busy", 64'(bus.busy), 64'd0);
    bus.cmd_en = 1'b1; bus.cmd = 1'b1; bus.addr = a; bus.data_mask = m; bus.wr_data = d0;
    step();
    bus.cmd_en = 1'b0; bus.wr_data = d1;
    step();
    bus.wr_data = d2;
    step();
    bus.wr_data = d3;
    step();
    bus.data_mask = 8'h00;
  endtask
  task automatic rd(input logic [20:0] a, input logic [63:0] e0, e1, e2, e3, input int n);
    logic [63:0] e [4];
    e = '{e0, e1, e2, e3};
    chk("rd_accept_busy", 64'(bus.busy), 64'd0);
    bus.cmd_en = 1'b1; bus.cmd = 1'b0; bus.addr = a;
    for (int k = 0; k < n; k++) sb.push_back(exp_t'{e[k], cyc + LAT + k});
    step();
    bus.cmd_en = 1'b0;
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.rd_data_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_valid cyc=%0d got=%h exp=no beat", cyc, bus.rd_data);
      end else begin
        e = sb.pop_front();
        chk("rd_data", bus.rd_data, e.data);
        chk("rd_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end
  initial begin
    #30000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd = 1'b0; bus.cmd_en = 1'b0; bus.addr = '0; bus.wr_data = '0; bus.data_mask = '0;
    repeat (3) step();
    chk("rst_valid", 64'(bus.rd_data_valid), 64'd0);
    chk("rst_calib", 64'(bus.init_calib), 64'd0);
    chk("rst_err", 64'(bus.cmd_error), 64'd0);
    chk("rst_rd_data", bus.rd_data, 64'd0);
    rst = 1'b0;
    repeat (5) step();
    bus.cmd_en = 1'b1; bus.cmd = 1'b0; bus.addr = '0;
    step();
    bus.cmd_en = 1'b0;
    chk("early_cmd_err", 64'(bus.cmd_error), 64'd1);
    repeat (9) step();
    chk("calib_at_15", 64'(bus.init_calib), 64'd0);
    chk("busy_at_15", 64'(bus.busy), 64'd1);
    step();
    chk("calib_at_16", 64'(bus.init_calib), 64'd1);
    wr(21'h40, D1, D2, D3, D4, 8'h00);
    repeat (10) step();
    rd(21'h40, D1, D2, D3, D4, 4);
    repeat (13) step();
    chk("idle_valid", 64'(bus.rd_data_valid), 64'd0);
    chk("rd_data_hold", bus.rd_data, D4);
    wr(21'h1FF003, B0, B0, B0, B0, 8'h00);
    repeat (10) step();
    wr(21'h0FFF, A0, A1, A2, A3, 8'h00);
    repeat (10) step();
    rd(21'h0FFF, A0, A1, A2, A3, 4);
    repeat (13) step();
    rd(21'h0000, A1, A2, A3, B0, 4);
    repeat (13) step();
    wr(21'h80, '1, '1, '1, '1, 8'h00);
    repeat (10) step();
    wr(21'h80, '0, '0, '0, '0, 8'h0F);
    repeat (10) step();
    rd(21'h80, MV, MV, MV, MV, 4);
    repeat (13) step();
    rd(21'h40, D1, D2, '0, '0, 2);
    repeat (8) step();
    rst = 1'b1;
    step();
    chk("abort_valid", 64'(bus.rd_data_valid), 64'd0);
    chk("abort_calib", 64'(bus.init_calib), 64'd0);
    chk("abort_err", 64'(bus.cmd_error), 64'd0);
    chk("abort_rd_data", bus.rd_data, 64'd0);
    chk("abort_drain", 64'(sb.size()), 64'd0);
    rst = 1'b0;
    repeat (15) step();
    chk("recal_at_15", 64'(bus.init_calib), 64'd0);
    step();
    chk("recal_at_16", 64'(bus.init_calib), 64'd1);
    rd(21'h40, D1, D2, D3, D4, 4);
    repeat (13) step();
    rd(21'h80, MV, MV, MV, MV, 4);
    repeat (12) step();
    chk("busy_t13", 64'(bus.busy), 64'd1);
    chk("err_before_t13", 64'(bus.cmd_error), 64'd0);
    bus.cmd_en = 1'b1; bus.cmd = 1'b1; bus.addr = 21'h40; bus.wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    bus.cmd_en = 1'b0;
    chk("err_after_t13", 64'(bus.cmd_error), 64'd1);
    rd(21'h40, D1, D2, D3, D4, 4);
    repeat (14) step();
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    chk("final_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/burst_ram_responder.md
Name: burst_ram_responder

Overview:
- Synthesizable target side of the burst RAM command interface; the cache and other bus masters drive it as initiators.
- Accepts read/write commands and moves one burst of 4 x 64-bit beats per command.
- Backed by on-chip block RAM with a programmable read latency, a command interval and a calibration delay. These mimic the external PSRAM controller.
- Drops in for the PSRAM IP in simulation and on boards without PSRAM.

Parameters:
- DEPTH_BITWIDTH, 21: width of addr; addr counts 64-bit words.
- STORAGE_BITWIDTH, 12: log2 of the implemented words (4096 x 8 B). Upper address bits are ignored.
- READ_LATENCY, 8: cycles from read cmd_en to the first rd_data_valid. Legal range 2..31.
- COMMAND_INTERVAL, 14: minimum number of cycles between accepted commands.
- INIT_CYCLES, 16: cycles after reset before init_calib rises.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd  in  1  0: read, 1: write
- cmd_en  in  1  cmd and addr valid this cycle
- addr  in  DEPTH_BITWIDTH  start word address of the burst
- wr_data  in  64  write beat data
- data_mask  in  8  per-byte mask; 1 = do not write the byte
- rd_data  out  64  read beat data
- rd_data_valid  out  1  rd_data valid this cycle
- init_calib  out  1  ready for commands
- busy  out  1  a command would not be accepted now
- cmd_error  out  1  sticky: a command arrived while busy

Behaviour:
- Reset: rd_data=0, rd_data_valid=0, init_calib=0, cmd_error=0, interval counter=0, state=INIT. Storage contents are not cleared.
  - Reset asserted mid-burst aborts the burst immediately.
  - Write beats not yet stored are lost.
- INIT: counts INIT_CYCLES, then init_calib=1 and state becomes IDLE.
- busy = !init_calib || state!=IDLE || interval_counter!=0. It is combinational.
- Accept: cmd_en=1 && !busy at cycle T.
  - Latch addr truncated to STORAGE_BITWIDTH.
  - Load interval_counter = COMMAND_INTERVAL-1. The counter decrements every cycle while nonzero.
  - The earliest next accept is T+COMMAND_INTERVAL, and only if state is back in IDLE.
- Reject: cmd_en=1 && busy sets cmd_error=1 (held until rst). The command is ignored and nothing else changes.
- Write burst (IDLE -> WRITE -> IDLE):
  - Beat 0 is wr_data sampled at T itself.
  - Beats 1..3 are sampled at T+1..T+3. The initiator holds no handshake; beats must be back-to-back.
  - Beat k is stored at (addr+k) mod 2^STORAGE_BITWIDTH.
  - State returns to IDLE after T+3.
  - A read of the same words accepted later returns the new data.
- Read burst (IDLE -> READ_WAIT -> READ_DATA -> IDLE):
  - rd_data_valid=1 for exactly 4 consecutive cycles, T+READ_LATENCY .. T+READ_LATENCY+3.
  - rd_data carries beat k = word (addr+k) mod 2^STORAGE_BITWIDTH.
  - Outside valid cycles, rd_data holds the last beat.
  - State returns to IDLE after the last beat.
- Address wrap: a burst at 0xFFF (STORAGE_BITWIDTH=12) touches 0xFFF, 0x000, 0x001, 0x002.
- The counter reaching 0 while still in WRITE or READ_*: busy stays high until IDLE.

Optional Feature:
- Macro BURST_RAM_DATA_MASK_EN.
- Defined: data_mask[i]=1 suppresses the write of byte i (bits 8i+7:8i) for that beat. The mask is sampled per beat alongside wr_data.
- Undefined: data_mask is ignored and all 8 bytes are written every beat. This matches the PSRAM IP as configured, where mask values have no effect.

Decomposition:
- Package burst_ram_pkg holds:
  - BURST_LENGTH=4 and CMD_READ=1'b0, CMD_WRITE=1'b1.
  - State enum {INIT, IDLE, WRITE, READ_WAIT, READ_DATA}.
  - Beat counter width 2.
- One sub-module, burst_ram_storage:
  - Simple dual-port 64-bit RAM, 2^STORAGE_BITWIDTH deep, 8 byte write enables, registered read port (1-cycle read latency).
  - The responder compensates with READ_LATENCY-1 wait cycles before issuing read addresses.

Test Plan:
- Calibration: assert rst 3 cycles, release. init_calib rises after exactly 16 cycles. A cmd_en at cycle 5 sets cmd_error=1 and does not start a burst.
- Write then read (READ_LATENCY=8):
  - Write @addr=0x40 with beats 0x1111..., 0x2222..., 0x3333..., 0x4444..., then wait 14 cycles.
  - Read @0x40: valid at T+8..T+11 returns the same four values in order, with no extra valid cycles.
- Interval enforcement: read accepted at T, second cmd_en at T+13 sets cmd_error=1 and is ignored. A cmd_en at T+14 is accepted, with busy low that cycle.
- Address wrap: write 4 beats at 0xFFF; reads at 0xFFF and 0x000 show beats 0,1,2,3 placed at 0xFFF, 0x000, 0x001, 0x002.
- Mask, write 0xFFFF... at 0x80, then write 0x0 with mask 0x0F on all beats:
  - Macro defined: read returns 0x00000000FFFFFFFF per beat.
  - Macro undefined: read returns 0x0.
- Reset mid-read: rst at T+9 gives rd_data_valid=0 from T+10 and init_calib=0. After INIT_CYCLES, a fresh read of previously written words returns the intact data.
